operand_stage: RTL and testbench

Execute-entry pipeline register for the RV32I core. It captures the decoded instruction from the decode stage and resolves its source operands, either from the register file or by forwarding from the EX, MEM or WB stages. It presents registered operands and the operation code directly to the combinational ALU, and it detects load-use hazards, stalling decode and inserting a bubble when one occurs.

---
 rtl/operand_stage_pkg.sv | 69 ++++++
 rtl/operand_stage_forward.sv | 33 +++
 rtl/operand_stage.sv | 161 ++++++++++++++++
 tb/tb_operand_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_stage_pkg.sv
// rtl/operand_stage_pkg.sv - shared types for the execute-entry operand stage
// Datapath widths, ALU op codes, operand selectors and the registered slot layout.
package operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int GPR_AW = 5;

  typedef logic [DATA_W-1:0] Data;
  typedef logic [GPR_AW-1:0] GPRAddr;

  typedef enum logic [3:0] {
    AluOp_ADD  = 4'd0,
    AluOp_SUB  = 4'd1,
    AluOp_SLL  = 4'd2,
    AluOp_SLT  = 4'd3,
    AluOp_SLTU = 4'd4,
    AluOp_XOR  = 4'd5,
    AluOp_SRL  = 4'd6,
    AluOp_SRA  = 4'd7,
    AluOp_OR   = 4'd8,
    AluOp_AND  = 4'd9
  } AluOp;

  typedef enum logic [1:0] {
    OpSelA_RS1  = 2'd0,
    OpSelA_PC   = 2'd1,
    OpSelA_ZERO = 2'd2
  } OpSelA;

  typedef enum logic [1:0] {
    OpSelB_RS2  = 2'd0,
    OpSelB_IMM  = 2'd1,
    OpSelB_FOUR = 2'd2
  } OpSelB;

  localparam Data DATA_FOUR = 32'd4;

  typedef struct packed {
    logic   valid;
    logic   reg_wr;
    logic   is_load;
    logic   is_store;
    AluOp   op;
    Data    operand_a;
    Data    operand_b;
    Data    store_data;
    Data    pc;
    GPRAddr rd_addr;
  } ex_slot_t;

  // Reset value and bubble share one encoding so a killed slot looks like a reset slot.
  localparam ex_slot_t EX_BUBBLE = '{
    valid:      1'b0,
    reg_wr:     1'b0,
    is_load:    1'b0,
    is_store:   1'b0,
    op:         AluOp_ADD,
    operand_a:  '0,
    operand_b:  '0,
    store_data: '0,
    pc:         '0,
    rd_addr:    '0
  };

  function automatic logic gpr_hit(input GPRAddr src, input GPRAddr dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/operand_stage_forward.sv
// rtl/operand_stage_forward.sv - per-source forwarding priority mux (EX > MEM > WB > regfile)
// Purely combinational; x0 reads as zero regardless of any writer.
module operand_forward
  import operand_stage_pkg::*;
(
  input  logic [4:0]  i_rs_addr,
  input  logic [31:0] i_rf_data,
  input  logic        i_ex_wr,
  input  logic [4:0]  i_ex_rd,
  input  logic [31:0] i_ex_data,
  input  logic        i_mem_wr,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_data,
  input  logic        i_wb_wr,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_rf_data;
    if (i_rs_addr == '0) begin
      o_data = '0;
    end else if (i_ex_wr && gpr_hit(i_rs_addr, i_ex_rd)) begin
      o_data = i_ex_data;
    end else if (i_mem_wr && gpr_hit(i_rs_addr, i_mem_rd)) begin
      o_data = i_mem_data;
    end else if (i_wb_wr && gpr_hit(i_rs_addr, i_wb_rd)) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - execute-entry pipeline register with forwarding and load-use stall
// Resolves source operands, registers them for the ALU, and inserts a bubble on load-use.
module operand_stage
  import operand_stage_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_rs1Addr,
  input  logic [4:0]  i_rs2Addr,
  input  logic [31:0] i_rs1Data,
  input  logic [31:0] i_rs2Data,
  input  logic [31:0] i_imm,
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_selA,
  input  logic [1:0]  i_selB,
  input  logic [4:0]  i_rdAddr,
  input  logic        i_regWrEnable,
  input  logic        i_isLoad,
  input  logic        i_isStore,
  input  logic [31:0] i_aluResult,
  input  logic        i_memValid,
  input  logic        i_memRegWr,
  input  logic [4:0]  i_memRdAddr,
  input  logic [31:0] i_memResult,
  input  logic        i_wbValid,
  input  logic        i_wbRegWr,
  input  logic [4:0]  i_wbRdAddr,
  input  logic [31:0] i_wbResult,
  input  logic        i_hold,
  input  logic        i_flush,
  output logic        o_stallUp,
  output logic        o_valid,
  output logic        o_regWrEnable,
  output logic        o_isLoad,
  output logic        o_isStore,
  output logic [3:0]  o_op,
  output logic [31:0] o_operandA,
  output logic [31:0] o_operandB,
  output logic [31:0] o_storeData,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rdAddr
);

  ex_slot_t slot_q, slot_d;

  Data   fwd1, fwd2;
  Data   operand_a, operand_b;
  OpSelA sel_a;
  OpSelB sel_b;
  logic  ex_wr, mem_wr, wb_wr;
  logic  load_in_ex, rs1_dep, rs2_dep, hazard;

  // A load in EX has no result yet; it is covered by the hazard stall, not by forwarding.
  assign ex_wr  = slot_q.valid & slot_q.reg_wr & ~slot_q.is_load;
  assign mem_wr = i_memValid & i_memRegWr;
  assign wb_wr  = i_wbValid & i_wbRegWr;

  operand_forward u_fwd_rs1 (
    .i_rs_addr  (i_rs1Addr),
    .i_rf_data  (i_rs1Data),
    .i_ex_wr    (ex_wr),
    .i_ex_rd    (slot_q.rd_addr),
    .i_ex_data  (i_aluResult),
    .i_mem_wr   (mem_wr),
    .i_mem_rd   (i_memRdAddr),
    .i_mem_data (i_memResult),
    .i_wb_wr    (wb_wr),
    .i_wb_rd    (i_wbRdAddr),
    .i_wb_data  (i_wbResult),
    .o_data     (fwd1)
  );

  operand_forward u_fwd_rs2 (
    .i_rs_addr  (i_rs2Addr),
    .i_rf_data  (i_rs2Data),
    .i_ex_wr    (ex_wr),
    .i_ex_rd    (slot_q.rd_addr),
    .i_ex_data  (i_aluResult),
    .i_mem_wr   (mem_wr),
    .i_mem_rd   (i_memRdAddr),
    .i_mem_data (i_memResult),
    .i_wb_wr    (wb_wr),
    .i_wb_rd    (i_wbRdAddr),
    .i_wb_data  (i_wbResult),
    .o_data     (fwd2)
  );

  assign sel_a = OpSelA'(i_selA);
  assign sel_b = OpSelB'(i_selB);

  always_comb begin
    operand_a = '0;
    case (sel_a)
      OpSelA_RS1: operand_a = fwd1;
      OpSelA_PC:  operand_a = i_pc;
      default:    operand_a = '0;
    endcase
  end

  always_comb begin
    operand_b = '0;
    case (sel_b)
      OpSelB_RS2:  operand_b = fwd2;
      OpSelB_IMM:  operand_b = i_imm;
      OpSelB_FOUR: operand_b = DATA_FOUR;
      default:     operand_b = '0;
    endcase
  end

  // Stores consume rs2 as data even when operand B is the immediate.
  assign load_in_ex = slot_q.valid & slot_q.is_load & slot_q.reg_wr & (slot_q.rd_addr != '0);
  assign rs1_dep    = (sel_a == OpSelA_RS1) & (i_rs1Addr == slot_q.rd_addr);
  assign rs2_dep    = ((sel_b == OpSelB_RS2) | i_isStore) & (i_rs2Addr == slot_q.rd_addr);
  assign hazard     = load_in_ex & i_valid & (rs1_dep | rs2_dep);

  assign o_stallUp  = ~i_flush & (i_hold | hazard);

  always_comb begin
    slot_d = slot_q;
    if (i_flush) begin
      slot_d = EX_BUBBLE;
    end else if (i_hold) begin
      slot_d = slot_q;
    end else if (hazard) begin
      slot_d = EX_BUBBLE;
    end else begin
      slot_d.valid      = i_valid;
      slot_d.reg_wr     = i_valid & i_regWrEnable;
      slot_d.is_load    = i_valid & i_isLoad;
      slot_d.is_store   = i_valid & i_isStore;
      slot_d.op         = AluOp'(i_op);
      slot_d.operand_a  = operand_a;
      slot_d.operand_b  = operand_b;
      slot_d.store_data = fwd2;
      slot_d.pc         = i_pc;
      slot_d.rd_addr    = i_rdAddr;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      slot_q <= EX_BUBBLE;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign o_valid       = slot_q.valid;
  assign o_regWrEnable = slot_q.reg_wr;
  assign o_isLoad      = slot_q.is_load;
  assign o_isStore     = slot_q.is_store;
  assign o_op          = slot_q.op;
  assign o_operandA    = slot_q.operand_a;
  assign o_operandB    = slot_q.operand_b;
  assign o_storeData   = slot_q.store_data;
  assign o_pc          = slot_q.pc;
  assign o_rdAddr      = slot_q.rd_addr;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - scoreboard bench for operand_stage
// Driver queues hand-computed expectations; a monitor pops and compares them.
module tb_operand_stage;
  import operand_stage_pkg::*;

  logic        clk, rst;
  logic        i_valid, i_regWrEnable, i_isLoad, i_isStore;
  logic [31:0] i_pc, i_rs1Data, i_rs2Data, i_imm, i_aluResult, i_memResult, i_wbResult;
  logic [4:0]  i_rs1Addr, i_rs2Addr, i_rdAddr, i_memRdAddr, i_wbRdAddr;
  logic [3:0]  i_op;
  logic [1:0]  i_selA, i_selB;
  logic        i_memValid, i_memRegWr, i_wbValid, i_wbRegWr, i_hold, i_flush;
  logic        o_stallUp, o_valid, o_regWrEnable, o_isLoad, o_isStore;
  logic [3:0]  o_op;
  logic [31:0] o_operandA, o_operandB, o_storeData, o_pc;
  logic [4:0]  o_rdAddr;

  operand_stage dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .i_pc(i_pc),
    .i_rs1Addr(i_rs1Addr), .i_rs2Addr(i_rs2Addr), .i_rs1Data(i_rs1Data), .i_rs2Data(i_rs2Data),
    .i_imm(i_imm), .i_op(i_op), .i_selA(i_selA), .i_selB(i_selB), .i_rdAddr(i_rdAddr),
    .i_regWrEnable(i_regWrEnable), .i_isLoad(i_isLoad), .i_isStore(i_isStore),
    .i_aluResult(i_aluResult), .i_memValid(i_memValid), .i_memRegWr(i_memRegWr),
    .i_memRdAddr(i_memRdAddr), .i_memResult(i_memResult), .i_wbValid(i_wbValid),
    .i_wbRegWr(i_wbRegWr), .i_wbRdAddr(i_wbRdAddr), .i_wbResult(i_wbResult),
    .i_hold(i_hold), .i_flush(i_flush), .o_stallUp(o_stallUp), .o_valid(o_valid),
    .o_regWrEnable(o_regWrEnable), .o_isLoad(o_isLoad), .o_isStore(o_isStore), .o_op(o_op),
    .o_operandA(o_operandA), .o_operandB(o_operandB), .o_storeData(o_storeData),
    .o_pc(o_pc), .o_rdAddr(o_rdAddr)
  );

  typedef struct {
    logic valid; Data pc; GPRAddr rs1, rs2; Data d1, d2, imm; AluOp op;
    OpSelA sa; OpSelB sb; GPRAddr rd; logic rw, ld, st; Data alu;
    logic mv, mw; GPRAddr mrd; Data mres; logic wv, ww; GPRAddr wrd; Data wres;
    logic hold, flush;
  } stim_t;

  typedef struct {
    int id; logic stall; logic valid, rw, ld, st; AluOp op;
    Data a, b, sd, pc; GPRAddr rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t ins(Data pc, GPRAddr rs1, Data d1, GPRAddr rs2, Data d2, Data imm,
                                OpSelA sa, OpSelB sb, GPRAddr rd, logic rw, logic ld, logic st,
                                AluOp op);
    stim_t s;
    s.valid = 1'b1; s.pc = pc; s.rs1 = rs1; s.d1 = d1; s.rs2 = rs2; s.d2 = d2; s.imm = imm;
    s.sa = sa; s.sb = sb; s.rd = rd; s.rw = rw; s.ld = ld; s.st = st; s.op = op;
    s.alu = '0; s.mv = 1'b0; s.mw = 1'b0; s.mrd = '0; s.mres = '0;
    s.wv = 1'b0; s.ww = 1'b0; s.wrd = '0; s.wres = '0; s.hold = 1'b0; s.flush = 1'b0;
    return s;
  endfunction

  function automatic exp_t ex(int id, logic stall, Data a, Data b, Data sd, Data pc, GPRAddr rd,
                              logic rw, logic ld, logic st, AluOp op);
    exp_t e;
    e.id = id; e.stall = stall; e.valid = 1'b1; e.a = a; e.b = b; e.sd = sd; e.pc = pc;
    e.rd = rd; e.rw = rw; e.ld = ld; e.st = st; e.op = op;
    return e;
  endfunction

  function automatic exp_t bub(int id, logic stall);
    exp_t e;
    e = ex(id, stall, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, AluOp_ADD);
    e.valid = 1'b0;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    i_valid = s.valid; i_pc = s.pc; i_rs1Addr = s.rs1; i_rs2Addr = s.rs2;
    i_rs1Data = s.d1; i_rs2Data = s.d2; i_imm = s.imm; i_op = s.op;
    i_selA = s.sa; i_selB = s.sb; i_rdAddr = s.rd;
    i_regWrEnable = s.rw; i_isLoad = s.ld; i_isStore = s.st; i_aluResult = s.alu;
    i_memValid = s.mv; i_memRegWr = s.mw; i_memRdAddr = s.mrd; i_memResult = s.mres;
    i_wbValid = s.wv; i_wbRegWr = s.ww; i_wbRdAddr = s.wrd; i_wbResult = s.wres;
    i_hold = s.hold; i_flush = s.flush;
  endtask

  task automatic apply(input stim_t s, input exp_t e);
    @(posedge clk);
    #2;
    drive(s);
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".valid"}, {31'b0, o_valid}, 32'd0);
    chk({tag, ".regwr"}, {31'b0, o_regWrEnable}, 32'd0);
    chk({tag, ".load"},  {31'b0, o_isLoad}, 32'd0);
    chk({tag, ".store"}, {31'b0, o_isStore}, 32'd0);
    chk({tag, ".op"},    {28'b0, o_op}, 32'd0);
    chk({tag, ".opA"},   o_operandA, 32'd0);
    chk({tag, ".opB"},   o_operandB, 32'd0);
    chk({tag, ".sd"},    o_storeData, 32'd0);
    chk({tag, ".pc"},    o_pc, 32'd0);
    chk({tag, ".rd"},    {27'b0, o_rdAddr}, 32'd0);
  endtask

  // Monitor: stall is combinational on the inputs of the current cycle, registered
  // fields are compared just after the edge that captured them.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d.stall", e.id), {31'b0, o_stallUp}, {31'b0, e.stall});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.valid", e.id), {31'b0, o_valid}, {31'b0, e.valid});
        chk($sformatf("v%0d.regwr", e.id), {31'b0, o_regWrEnable}, {31'b0, e.rw});
        chk($sformatf("v%0d.load", e.id),  {31'b0, o_isLoad}, {31'b0, e.ld});
        chk($sformatf("v%0d.store", e.id), {31'b0, o_isStore}, {31'b0, e.st});
        chk($sformatf("v%0d.op", e.id),    {28'b0, o_op}, {28'b0, e.op});
        chk($sformatf("v%0d.opA", e.id),   o_operandA, e.a);
        chk($sformatf("v%0d.opB", e.id),   o_operandB, e.b);
        chk($sformatf("v%0d.sd", e.id),    o_storeData, e.sd);
        chk($sformatf("v%0d.pc", e.id),    o_pc, e.pc);
        chk($sformatf("v%0d.rd", e.id),    {27'b0, o_rdAddr}, {27'b0, e.rd});
      end
    end
  end

  initial begin
    stim_t s;
    exp_t  e;
    rst = 1'b1;
    s = ins('0, '0, '0, '0, '0, '0, OpSelA_RS1, OpSelB_RS2, '0, 1'b0, 1'b0, 1'b0, AluOp_ADD);
    s.valid = 1'b0;
    drive(s);
    #1;
    chk_reset_state("reset0");
    #11;
    rst = 1'b0;

    // add x3,x1,x2 then sub x4,x3,x1 with x3 forwarded from EX
    s = ins(32'h100, 5'd1, 32'd5, 5'd2, 32'd3, '0, OpSelA_RS1, OpSelB_RS2, 5'd3, 1, 0, 0, AluOp_ADD);
    apply(s, ex(1, 0, 32'd5, 32'd3, 32'd3, 32'h100, 5'd3, 1, 0, 0, AluOp_ADD));
    s = ins(32'h104, 5'd3, 32'h99, 5'd1, 32'd5, '0, OpSelA_RS1, OpSelB_RS2, 5'd4, 1, 0, 0, AluOp_SUB);
    s.alu = 32'd8;
    apply(s, ex(2, 0, 32'd8, 32'd5, 32'd5, 32'h104, 5'd4, 1, 0, 0, AluOp_SUB));

    // lw x5 then add x6,x5,x0: one bubble, then MEM forward
    s = ins(32'h108, 5'd1, 32'd5, 5'd0, '0, 32'h10, OpSelA_RS1, OpSelB_IMM, 5'd5, 1, 1, 0, AluOp_ADD);
    s.alu = 32'd3;
    apply(s, ex(3, 0, 32'd5, 32'h10, 32'd0, 32'h108, 5'd5, 1, 1, 0, AluOp_ADD));
    s = ins(32'h10C, 5'd5, '0, 5'd0, '0, '0, OpSelA_RS1, OpSelB_RS2, 5'd6, 1, 0, 0, AluOp_ADD);
    s.alu = 32'h15;
    apply(s, bub(4, 1));
    s.mv = 1; s.mw = 1; s.mrd = 5'd5; s.mres = 32'hDEADBEEF;
    apply(s, ex(5, 0, 32'hDEADBEEF, 32'd0, 32'd0, 32'h10C, 5'd6, 1, 0, 0, AluOp_ADD));

    // x0 is never forwarded and never reads nonzero
    s = ins(32'h110, 5'd0, 32'h55, 5'd0, 32'h66, '0, OpSelA_RS1, OpSelB_RS2, 5'd8, 1, 0, 0, AluOp_ADD);
    s.mv = 1; s.mw = 1; s.mrd = 5'd0; s.mres = 32'h1234;
    apply(s, ex(6, 0, 32'd0, 32'd0, 32'd0, 32'h110, 5'd8, 1, 0, 0, AluOp_ADD));

    // MEM beats WB; WB alone; EX beats MEM
    s = ins(32'h114, 5'd7, 32'h11, 5'd7, 32'h22, '0, OpSelA_RS1, OpSelB_RS2, 5'd9, 1, 0, 0, AluOp_ADD);
    s.mv = 1; s.mw = 1; s.mrd = 5'd7; s.mres = 32'hAA;
    s.wv = 1; s.ww = 1; s.wrd = 5'd7; s.wres = 32'hBB;
    apply(s, ex(7, 0, 32'hAA, 32'hAA, 32'hAA, 32'h114, 5'd9, 1, 0, 0, AluOp_ADD));
    s = ins(32'h118, 5'd7, 32'h11, 5'd0, '0, '0, OpSelA_RS1, OpSelB_RS2, 5'd10, 1, 0, 0, AluOp_ADD);
    s.wv = 1; s.ww = 1; s.wrd = 5'd7; s.wres = 32'hBB;
    apply(s, ex(8, 0, 32'hBB, 32'd0, 32'd0, 32'h118, 5'd10, 1, 0, 0, AluOp_ADD));
    s = ins(32'h11C, 5'd10, 32'h11, 5'd0, '0, '0, OpSelA_RS1, OpSelB_FOUR, 5'd11, 1, 0, 0, AluOp_ADD);
    s.alu = 32'h77; s.mv = 1; s.mw = 1; s.mrd = 5'd10; s.mres = 32'h66;
    apply(s, ex(9, 0, 32'h77, 32'd4, 32'd0, 32'h11C, 5'd11, 1, 0, 0, AluOp_ADD));
    s = ins(32'h120, 5'd0, '0, 5'd0, '0, 32'hFFFFFFF0, OpSelA_PC, OpSelB_IMM, 5'd12, 1, 0, 0, AluOp_ADD);
    apply(s, ex(10, 0, 32'h120, 32'hFFFFFFF0, 32'd0, 32'h120, 5'd12, 1, 0, 0, AluOp_ADD));

    // hold 3 cycles with a new instruction waiting, then release
    s = ins(32'h124, 5'd1, 32'd5, 5'd2, 32'd3, '0, OpSelA_RS1, OpSelB_RS2, 5'd13, 1, 0, 0, AluOp_ADD);
    s.hold = 1;
    for (int i = 11; i <= 13; i++) begin
      e = ex(i, 1, 32'h120, 32'hFFFFFFF0, 32'd0, 32'h120, 5'd12, 1, 0, 0, AluOp_ADD);
      apply(s, e);
    end
    s.hold = 0;
    apply(s, ex(14, 0, 32'd5, 32'd3, 32'd3, 32'h124, 5'd13, 1, 0, 0, AluOp_ADD));

    // load x14, store of x14 under hold: hazard survives release, then MEM forward to store data
    s = ins(32'h128, 5'd1, 32'd5, 5'd0, '0, 32'd4, OpSelA_RS1, OpSelB_IMM, 5'd14, 1, 1, 0, AluOp_ADD);
    apply(s, ex(15, 0, 32'd5, 32'd4, 32'd0, 32'h128, 5'd14, 1, 1, 0, AluOp_ADD));
    s = ins(32'h12C, 5'd1, 32'd5, 5'd14, '0, '0, OpSelA_RS1, OpSelB_IMM, 5'd0, 0, 0, 1, AluOp_ADD);
    s.hold = 1;
    apply(s, ex(16, 1, 32'd5, 32'd4, 32'd0, 32'h128, 5'd14, 1, 1, 0, AluOp_ADD));
    s.hold = 0;
    apply(s, bub(17, 1));
    s.mv = 1; s.mw = 1; s.mrd = 5'd14; s.mres = 32'hCAFE;
    apply(s, ex(18, 0, 32'd5, 32'd0, 32'hCAFE, 32'h12C, 5'd0, 0, 0, 1, AluOp_ADD));

    // flush together with hold and hazard: bubble, no stall
    s = ins(32'h130, 5'd1, 32'd5, 5'd0, '0, 32'd8, OpSelA_RS1, OpSelB_IMM, 5'd15, 1, 1, 0, AluOp_ADD);
    apply(s, ex(19, 0, 32'd5, 32'd8, 32'd0, 32'h130, 5'd15, 1, 1, 0, AluOp_ADD));
    s = ins(32'h134, 5'd15, '0, 5'd0, '0, '0, OpSelA_RS1, OpSelB_RS2, 5'd16, 1, 0, 0, AluOp_ADD);
    s.hold = 1; s.flush = 1;
    apply(s, bub(20, 0));
    s = ins(32'h138, 5'd1, 32'd5, 5'd2, 32'd3, '0, OpSelA_ZERO, OpSelB_RS2, 5'd16, 1, 0, 0, AluOp_ADD);
    apply(s, ex(21, 0, 32'd0, 32'd3, 32'd3, 32'h138, 5'd16, 1, 0, 0, AluOp_ADD));

    // async reset mid-cycle, released before the next edge which must capture again
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_state("reset_mid");
    rst = 1'b0;
    exp_q.push_back(ex(22, 0, 32'd0, 32'd3, 32'd3, 32'h138, 5'd16, 1, 0, 0, AluOp_ADD));

    s = ins(32'h13C, 5'd16, '0, 5'd0, '0, '0, OpSelA_RS1, OpSelB_FOUR, 5'd17, 1, 0, 0, AluOp_SUB);
    s.alu = 32'd9;
    apply(s, ex(23, 0, 32'd9, 32'd4, 32'd0, 32'h13C, 5'd17, 1, 0, 0, AluOp_SUB));

    // empty decode slot: data still captured, controls gated
    s = ins(32'h140, 5'd1, 32'd5, 5'd2, 32'd3, '0, OpSelA_RS1, OpSelB_RS2, 5'd18, 1, 1, 1, AluOp_ADD);
    s.valid = 1'b0;
    e = ex(24, 0, 32'd5, 32'd3, 32'd3, 32'h140, 5'd18, 0, 0, 0, AluOp_ADD);
    e.valid = 1'b0;
    apply(s, e);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
